xdma_c2h_request_splitter: RTL and testbench

XDMA_C2H_REQUEST_SPLITTER -- requirements
Module: xdma_c2h_request_splitter

---
 rtl/xdma_c2h_request_splitter.sv | 115 +++++++++++
 tb/tb_xdma_c2h_request_splitter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xdma_c2h_request_splitter.sv
// Splits C2H transfer requests into descriptor commands that never cross a
// MAX_CHUNK-aligned address window. One request is processed at a time.
module xdma_c2h_request_splitter #(
   parameter int unsigned LOG2_MAX_CHUNK = 16
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [95:0]   S_AXIS_tdata,
   input  logic          S_AXIS_tvalid,
   output logic          S_AXIS_tready,
   output logic [103:0]  M_AXIS_tdata,
   output logic          M_AXIS_tvalid,
   input  logic          M_AXIS_tready,
   output logic [31:0]   req_count,
   output logic [31:0]   dsc_count,
   output logic [31:0]   zero_len_count
);

   localparam logic [32:0] MAX_CHUNK = 33'(1) << LOG2_MAX_CHUNK;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Handshakes on both sides follow AXI-Stream rules: a transfer happens on
   // the rising edge where valid and ready are both high; a valid source holds
   // its data unchanged until that edge.
   state_t          state_q;
   logic [63:0]     addr_q;
   logic [31:0]     rem_q;
   logic [103:0]    m_tdata_q;
   logic            m_tvalid_q;
   logic [31:0]     req_cnt_q;
   logic [31:0]     dsc_cnt_q;
   logic [31:0]     zero_cnt_q;

   logic            s_hs_d;
   logic            m_hs_d;
   logic [63:0]     next_addr_d;
   logic [31:0]     next_rem_d;
   logic [32:0]     win_d;
   logic [32:0]     chunk_d;
   logic [103:0]    next_desc_d;

   assign S_AXIS_tready  = (state_q == IDLE) & resetn;
   assign M_AXIS_tdata   = m_tdata_q;
   assign M_AXIS_tvalid  = m_tvalid_q;
   assign req_count      = req_cnt_q;
   assign dsc_count      = dsc_cnt_q;
   assign zero_len_count = zero_cnt_q;

   assign s_hs_d = S_AXIS_tvalid & S_AXIS_tready;
   assign m_hs_d = m_tvalid_q & M_AXIS_tready;

   // The descriptor to present next is built from either the incoming request
   // (IDLE) or the position just past the descriptor now being handed off.
   always_comb begin
      next_addr_d = addr_q + 64'(m_tdata_q[22:0]);
      next_rem_d  = rem_q - 32'(m_tdata_q[22:0]);
      if (state_q == IDLE) begin
         next_addr_d = S_AXIS_tdata[95:32];
         next_rem_d  = S_AXIS_tdata[31:0];
      end
      win_d       = MAX_CHUNK - 33'(next_addr_d[LOG2_MAX_CHUNK-1:0]);
      chunk_d     = ({1'b0, next_rem_d} < win_d) ? {1'b0, next_rem_d} : win_d;
      next_desc_d = {7'd0, (chunk_d == {1'b0, next_rem_d}), next_addr_d,
                     9'd0, chunk_d[22:0]};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         req_cnt_q  <= '0;
         dsc_cnt_q  <= '0;
         zero_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (s_hs_d) begin
                  if (S_AXIS_tdata[31:0] == 32'd0) begin
                     zero_cnt_q <= zero_cnt_q + 32'd1;
                  end else begin
                     addr_q     <= next_addr_d;
                     rem_q      <= next_rem_d;
                     m_tdata_q  <= next_desc_d;
                     m_tvalid_q <= 1'b1;
                     req_cnt_q  <= req_cnt_q + 32'd1;
                     state_q    <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (m_hs_d) begin
                  dsc_cnt_q <= dsc_cnt_q + 32'd1;
                  if (m_tdata_q[96]) begin
                     m_tvalid_q <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     addr_q    <= next_addr_d;
                     rem_q     <= next_rem_d;
                     m_tdata_q <= next_desc_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xdma_c2h_request_splitter.sv
// Directed and randomized checks of the C2H request splitter against a
// scoreboard of expected descriptors.
module tb_xdma_c2h_request_splitter;
  localparam int unsigned LOG2 = 16;
  localparam longint unsigned MAXC = 64'd1 << LOG2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [95:0]   S_AXIS_tdata;
  logic          S_AXIS_tvalid;
  logic          S_AXIS_tready;
  logic [103:0]  M_AXIS_tdata;
  logic          M_AXIS_tvalid;
  logic          M_AXIS_tready;
  logic [31:0]   req_count;
  logic [31:0]   dsc_count;
  logic [31:0]   zero_len_count;

  int n_chk = 0;
  int n_pass = 0;
  logic [103:0] exp_q[$];
  logic [31:0] exp_req = 0;
  logic [31:0] exp_dsc = 0;
  logic [31:0] exp_zero = 0;
  int seen_in_window = 0;

  xdma_c2h_request_splitter #(.LOG2_MAX_CHUNK(LOG2)) dut (
    .clk(clk),
    .resetn(resetn),
    .S_AXIS_tdata(S_AXIS_tdata),
    .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tready(S_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata),
    .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready),
    .req_count(req_count),
    .dsc_count(dsc_count),
    .zero_len_count(zero_len_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [103:0] desc(input logic [63:0] a, input logic [31:0] l, input logic last);
    logic [22:0] l23;
    l23 = l[22:0];
    return {7'd0, last, a, 9'd0, l23};
  endfunction

  // Reference split: walk the request window by window.
  function automatic int model_push(input logic [63:0] a, input logic [31:0] len);
    longint unsigned addr, rem, room, c;
    int n;
    addr = a;
    rem = len;
    n = 0;
    while (rem != 0) begin
      room = MAXC - (addr % MAXC);
      c = (rem < room) ? rem : room;
      exp_q.push_back(desc(addr, 32'(c), c == rem));
      addr = addr + c;
      rem = rem - c;
      n++;
    end
    return n;
  endfunction

  // Monitor: every descriptor handoff is compared against the scoreboard.
  always @(negedge clk) begin
    if (resetn && M_AXIS_tvalid && M_AXIS_tready) begin
      seen_in_window++;
      chk("s_ready_low_while_emit", S_AXIS_tready, 1'b0);
      if (exp_q.size() == 0) chk("unexpected_desc", M_AXIS_tdata, 104'd0 - 1);
      else chk("desc", M_AXIS_tdata, exp_q.pop_front());
    end
    if (!resetn) chk("s_ready_in_reset", S_AXIS_tready, 1'b0);
  end

  task automatic send(input logic [63:0] a, input logic [31:0] len);
    int t = 0;
    S_AXIS_tdata = {a, len};
    S_AXIS_tvalid = 1'b1;
    while (!S_AXIS_tready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("accept_timeout", t < 200, 1'b1);
    @(posedge clk); #1;
    S_AXIS_tvalid = 1'b0;
    chk("tvalid_latency", M_AXIS_tvalid, len != 0);
  endtask

  task automatic drain(input int exp_cycles, input bit rnd);
    int t = 0;
    while ((exp_q.size() != 0 || M_AXIS_tvalid) && t < 3000) begin
      if (rnd) M_AXIS_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; t++;
    end
    M_AXIS_tready = 1'b1;
    chk("drain_timeout", t < 3000, 1'b1);
    if (exp_cycles >= 0) chk("drain_cycles", t, exp_cycles);
    chk("s_ready_after_last", S_AXIS_tready, 1'b1);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_req"}, req_count, exp_req);
    chk({tag, "_dsc"}, dsc_count, exp_dsc);
    chk({tag, "_zero"}, zero_len_count, exp_zero);
  endtask

  initial begin
    logic [103:0] snap;
    logic [63:0] ra;
    logic [31:0] rl;
    int n;
    resetn = 1'b0;
    S_AXIS_tdata = '0;
    S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", S_AXIS_tready, 1'b0);
    chk("rst_m_valid", M_AXIS_tvalid, 1'b0);
    chk("rst_m_data", M_AXIS_tdata, 104'd0);
    chk_counters("rst");
    resetn = 1'b1;
    #1;
    chk("rst_release_s_ready", S_AXIS_tready, 1'b1);

    // Two full windows from an aligned address, back to back.
    exp_q.push_back(desc(64'h1_0000_0000, 32'h10000, 1'b0));
    exp_q.push_back(desc(64'h1_0001_0000, 32'h10000, 1'b1));
    send(64'h1_0000_0000, 32'h20000);
    drain(2, 1'b0);
    exp_req += 1; exp_dsc += 2;
    chk_counters("two_windows");

    // Unaligned start crossing one boundary.
    exp_q.push_back(desc(64'hF000, 32'h1000, 1'b0));
    exp_q.push_back(desc(64'h10000, 32'h2000, 1'b1));
    send(64'hF000, 32'h3000);
    drain(2, 1'b0);
    exp_req += 1; exp_dsc += 2;
    chk_counters("cross");

    // Small single-descriptor request.
    exp_q.push_back(desc(64'h40, 32'd100, 1'b1));
    send(64'h40, 32'd100);
    drain(1, 1'b0);
    exp_req += 1; exp_dsc += 1;
    chk_counters("single");

    // Zero-length request is counted and dropped.
    seen_in_window = 0;
    send(64'h1234, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_no_desc", seen_in_window, 0);
    chk("zero_s_ready", S_AXIS_tready, 1'b1);
    exp_zero += 1;
    chk_counters("zero");

    // Back-pressure: each descriptor stalled five cycles.
    exp_q.push_back(desc(64'h1_0000_0000, 32'h10000, 1'b0));
    exp_q.push_back(desc(64'h1_0001_0000, 32'h10000, 1'b1));
    M_AXIS_tready = 1'b0;
    send(64'h1_0000_0000, 32'h20000);
    for (int k = 0; k < 2; k++) begin
      snap = M_AXIS_tdata;
      repeat (5) begin
        @(posedge clk); #1;
      end
      chk("stall_valid", M_AXIS_tvalid, 1'b1);
      chk("stall_data", M_AXIS_tdata, snap);
      M_AXIS_tready = 1'b1;
      @(posedge clk); #1;
      M_AXIS_tready = 1'b0;
    end
    drain(0, 1'b0);
    exp_req += 1; exp_dsc += 2;
    chk_counters("stall");

    // Address wraps past 2^64.
    exp_q.push_back(desc(64'hFFFF_FFFF_FFFF_8000, 32'h8000, 1'b0));
    exp_q.push_back(desc(64'h0, 32'h8000, 1'b1));
    send(64'hFFFF_FFFF_FFFF_8000, 32'h10000);
    drain(2, 1'b0);
    exp_req += 1; exp_dsc += 2;
    chk_counters("wrap");

    // Random requests near window boundaries with random back-pressure.
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      ra[15:0] = 16'($urandom_range(0, 1) ? $urandom_range(16'hFF00, 16'hFFFF) : $urandom_range(0, 16'hFFFF));
      rl = 32'($urandom_range(1, 3 * 65536 + 77));
      n = model_push(ra, rl);
      send(ra, rl);
      drain(-1, 1'b1);
      exp_req += 1; exp_dsc += 32'(n);
    end
    chk_counters("random");

    // Reset mid-request discards the remaining chunks.
    M_AXIS_tready = 1'b0;
    send(64'h0, 32'h30000);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    M_AXIS_tready = 1'b1;
    seen_in_window = 0;
    #1;
    chk("post_rst_s_ready", S_AXIS_tready, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_desc", seen_in_window, 0);
    chk("post_rst_m_valid", M_AXIS_tvalid, 1'b0);
    exp_req = 0; exp_dsc = 0; exp_zero = 0;
    chk_counters("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
